// File: rtl/dmem_responder_pkg.sv
// Shared types and funct3 encodings for the MEM-stage data responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_responder_align.sv
// Byte-lane steering: store merge into the old word, load extraction with
// sign/zero extension, and legality of the funct3/alignment combination.
module load_store_align
    import dmem_pkg::*;
(
    input  logic        i_write,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_store_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data,
    output logic        o_illegal
);

    logic [31:0] w_wrep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_illegal = 1'b0;
        o_be      = 4'b0000;
        case (i_funct3)
            F3_B, F3_BU: o_be = 4'b0001 << i_lane;
            F3_H, F3_HU: begin
                o_be      = i_lane[1] ? 4'b1100 : 4'b0011;
                o_illegal = i_lane[0];
            end
            F3_W: begin
                o_be      = 4'b1111;
                o_illegal = (i_lane != 2'b00);
            end
            default: o_illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (i_write && i_funct3[2]) o_illegal = 1'b1;
        if (o_illegal) o_be = 4'b0000;
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_wrep = {4{i_wdata[7:0]}};
            2'b01:   w_wrep = {2{i_wdata[15:0]}};
            default: w_wrep = i_wdata;
        endcase
        o_store_word = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) o_store_word[8*i +: 8] = w_wrep[8*i +: 8];
        end
    end

    always_comb begin
        w_byte = i_rd_word[{i_lane, 3'b000} +: 8];
        w_half = i_rd_word[{i_lane[1], 4'b0000} +: 16];
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            F3_W:    o_load_data = i_rd_word;
            default: o_load_data = 32'd0;
        endcase
        if (o_illegal) o_load_data = 32'd0;
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: accepts one load/store, waits WAIT_CYCLES, then
// commits against the word RAM and pulses resp_valid while releasing stall.
//
// state | meaning
// IDLE  | ready for a request; stall follows req_valid
// WAIT  | counting down wait states, request latched
// RESP  | access committed; resp_valid pulse, pipeline advances
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  req_ready,
    output logic                  stall,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  misaligned
);

    localparam int         DEPTH     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (DATA_W != 32) begin : g_bad_width
        $error("DATA_W must be 32");
    end

    state_t                  r_state, w_next;
    logic [3:0]              r_cnt;
    logic                    r_write;
    logic [DM_ADDRESS-1:0]   r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [2:0]              r_funct3;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_mis;
    logic [DATA_W-1:0]       r_ram [DEPTH];

    logic                    w_accept, w_commit;
    logic                    w_sel_write;
    logic [DM_ADDRESS-1:0]   w_sel_addr;
    logic [DATA_W-1:0]       w_sel_wdata;
    logic [2:0]              w_sel_funct3;
    logic [DM_ADDRESS-3:0]   w_idx;
    logic [DATA_W-1:0]       w_word, w_store_word, w_load_data;
    logic [3:0]              w_be;
    logic                    w_illegal;

    // With zero wait states the commit edge is the accept edge, so the
    // access must be steered from the live request rather than the latches.
    assign w_sel_write  = (r_state == IDLE) ? req_write  : r_write;
    assign w_sel_addr   = (r_state == IDLE) ? req_addr   : r_addr;
    assign w_sel_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
    assign w_sel_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
    assign w_idx        = w_sel_addr[DM_ADDRESS-1:2];
    assign w_word       = r_ram[w_idx];
    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_commit     = (w_next == RESP) && (r_state != RESP);
    assign resp_rdata   = r_rdata;

    load_store_align u_align (
        .i_write      (w_sel_write),
        .i_funct3     (w_sel_funct3),
        .i_lane       (w_sel_addr[1:0]),
        .i_wdata      (w_sel_wdata),
        .i_old_word   (w_word),
        .i_rd_word    (w_word),
        .o_store_word (w_store_word),
        .o_be         (w_be),
        .o_load_data  (w_load_data),
        .o_illegal    (w_illegal)
    );

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        stall      = 1'b0;
        resp_valid = 1'b0;
        misaligned = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stall  = 1'b1;
                    w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (r_cnt <= 4'd1) w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                misaligned = r_mis;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'd0;
            r_rdata  <= '0;
            r_mis    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_ram[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= WAIT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= w_sel_write ? '0 : w_load_data;
                r_mis   <= w_illegal;
                if (w_sel_write && !w_illegal) r_ram[w_idx] <= w_store_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at 2, 0 and 4 wait states, checked
// against a byte-addressed memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [2:0]       vld, wr;
    logic [2:0][8:0]  addr;
    logic [2:0][31:0] wd;
    logic [2:0][2:0]  f3;
    wire  [2:0]       rdy, stl, rv, mis;
    wire  [2:0][31:0] rd;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_write(wr[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .req_funct3(f3[0]),
        .req_ready(rdy[0]), .stall(stl[0]), .resp_valid(rv[0]),
        .resp_rdata(rd[0]), .misaligned(mis[0]));
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_write(wr[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .req_funct3(f3[1]),
        .req_ready(rdy[1]), .stall(stl[1]), .resp_valid(rv[1]),
        .resp_rdata(rd[1]), .misaligned(mis[1]));
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(4)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(vld[2]), .req_write(wr[2]),
        .req_addr(addr[2]), .req_wdata(wd[2]), .req_funct3(f3[2]),
        .req_ready(rdy[2]), .stall(stl[2]), .resp_valid(rv[2]),
        .resp_rdata(rd[2]), .misaligned(mis[2]));

    typedef struct {
        int          d;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    exp_t       q[$];
    logic [7:0] bmem[3][512];
    int         waitc[3] = '{2, 0, 4};
    int         checks   = 0;
    int         failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: memory as bytes, little-endian, access size from funct3.
    function automatic void model(int d, bit w, logic [2:0] f, logic [8:0] a,
                                  logic [31:0] wdv, output logic ill,
                                  output logic [31:0] ld);
        int sz;
        sz  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        ill = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f[2]) ||
              ((int'(a) % sz) != 0);
        ld  = 32'd0;
        if (!ill) begin
            if (w) begin
                for (int i = 0; i < sz; i++) bmem[d][int'(a) + i] = wdv[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) ld |= 32'(bmem[d][int'(a) + i]) << (8*i);
                if (!f[2] && sz < 4 && ld[8*sz-1]) ld |= 32'hFFFF_FFFF << (8*sz);
            end
        end
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rv[d] === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_dut", 32'(d), 32'(e.d));
                    chk("misaligned", 32'(mis[d]), 32'(e.mis));
                    if (e.chk_rd) chk("resp_rdata", rd[d], e.rdata);
                end
            end
        end
    end

    task automatic req(input int d, input bit w, input logic [2:0] f,
                       input logic [8:0] a, input logic [31:0] wdv, input bit drop);
        logic        ill;
        logic [31:0] ld;
        int          cyc, st;
        exp_t        e;
        model(d, w, f, a, wdv, ill, ld);
        e.d = d; e.chk_rd = !w || ill; e.rdata = ld; e.mis = ill;
        q.push_back(e);
        @(negedge clk);
        vld[d] = 1'b1; wr[d] = w; f3[d] = f; addr[d] = a; wd[d] = wdv;
        cyc = 0; st = 0;
        #1;
        while (rv[d] !== 1'b1 && cyc < 40) begin
            st += int'(stl[d]);
            cyc++;
            @(negedge clk);
            if (drop) vld[d] = 1'b0;
            #1;
        end
        chk("latency", 32'(cyc), 32'(waitc[d] + 1));
        chk("stall_cycles", 32'(st), 32'(waitc[d] + 1));
        chk("stall_in_resp", 32'(stl[d]), 32'd0);
        vld[d] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vld   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) for (int i = 0; i < 512; i++) bmem[d][i] = 8'd0;
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vld = '0; wr = '0; addr = '0; wd = '0; f3 = '0;
        do_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", 32'(rdy[d]), 32'd1);
            chk("rst_resp_valid", 32'(rv[d]), 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
            chk("rst_misaligned", 32'(mis[d]), 32'd0);
            chk("rst_stall", 32'(stl[d]), 32'd0);
        end
        vld[0] = 1'b1; #1;
        chk("stall_comb", 32'(stl[0]), 32'd1);
        vld[0] = 1'b0; #1;
        chk("stall_comb_low", 32'(stl[0]), 32'd0);

        // Two wait states: word, byte, half, illegal cases.
        req(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 0);
        req(0, 0, 3'b010, 9'h010, 32'h0, 0);
        req(0, 1, 3'b010, 9'h010, 32'h11223344, 0);
        req(0, 1, 3'b000, 9'h013, 32'h00000080, 0);
        req(0, 0, 3'b000, 9'h013, 32'h0, 0);
        req(0, 0, 3'b100, 9'h013, 32'h0, 0);
        req(0, 0, 3'b010, 9'h010, 32'h0, 0);
        req(0, 1, 3'b001, 9'h022, 32'h00001234, 0);
        req(0, 0, 3'b001, 9'h022, 32'h0, 0);
        req(0, 0, 3'b101, 9'h020, 32'h0, 0);
        req(0, 0, 3'b010, 9'h005, 32'h0, 0);
        req(0, 1, 3'b001, 9'h001, 32'hFFFFFFFF, 0);
        req(0, 0, 3'b010, 9'h000, 32'h0, 0);
        req(0, 1, 3'b100, 9'h000, 32'hFFFFFFFF, 0);
        req(0, 0, 3'b111, 9'h000, 32'h0, 1);

        // Zero wait states: back-to-back store/load.
        req(1, 1, 3'b010, 9'h040, 32'hCAFEF00D, 0);
        req(1, 0, 3'b010, 9'h040, 32'h0, 0);
        req(1, 1, 3'b000, 9'h041, 32'h000000A5, 0);
        req(1, 0, 3'b001, 9'h040, 32'h0, 0);

        // Reset one cycle after a store accept aborts the write.
        @(negedge clk);
        vld[2] = 1'b1; wr[2] = 1'b1; f3[2] = 3'b010; addr[2] = 9'h030; wd[2] = 32'h55AA55AA;
        @(negedge clk);
        vld[2] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) for (int i = 0; i < 512; i++) bmem[d][i] = 8'd0;
        #1;
        chk("abort_ready", 32'(rdy[2]), 32'd1);
        chk("abort_resp_valid", 32'(rv[2]), 32'd0);
        chk("abort_stall", 32'(stl[2]), 32'd0);
        req(2, 0, 3'b010, 9'h030, 32'h0, 0);

        // Randomized traffic on every configuration.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                logic [2:0] f;
                logic [2:0] legal [5];
                legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                f = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) f = legal[$urandom_range(0, 4)];
                req(d, 1'($urandom_range(0, 1)), f, 9'($urandom_range(0, 63)),
                    32'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle responder for the pipeline's MEM-stage data port. It accepts one load or store per handshake and services it from an internal word-organised RAM after a programmable number of wait states. It performs byte/halfword/word lane handling and load sign extension per funct3, and drives a stall back to the pipeline until the response is delivered.

## Interface
- DM_ADDRESS, 9, byte address width; RAM depth = 2**(DM_ADDRESS-2) words
- DATA_W, 32, data width (fixed 32; other values unsupported)
- WAIT_CYCLES, 2, wait states inserted before the access (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- req_valid  in  1  MEM stage holds a load or store (MemRead|MemWrite)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_funct3  in  3  access size/sign
- req_ready  out  1  responder can accept (state IDLE)
- stall  out  1  hold PC/IF/ID/EX/MEM; request must stay stable while high
- resp_valid  out  1  one-cycle pulse, access complete
- resp_rdata  out  DATA_W  load result, valid with resp_valid
- misaligned  out  1  pulses with resp_valid on an illegal/misaligned access

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch write/addr/wdata/funct3 and load counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go directly to RESP.
- WAIT: decrement counter. Transition to RESP on the edge where counter==1.
- Access commit (RAM write or registered RAM read into resp_rdata) happens on the edge entering RESP.
- RESP: resp_valid=1, stall=0 (pipeline advances, capturing resp_rdata). Next state is IDLE unconditionally.
- stall = (state==IDLE && req_valid) || state==WAIT.
- Word index = addr[DM_ADDRESS-1:2]; lane = addr[1:0].
- Stores:
  - SB (000) writes byte lane addr[1:0] from wdata[7:0].
  - SH (001) writes lanes {addr[1],0} from wdata[15:0].
  - SW (010) writes all lanes.
  - Unwritten lanes are preserved.
- Loads:
  - LB (000) / LBU (100) return the lane byte, sign- or zero-extended.
  - LH (001) / LHU (101) return the halfword, sign- or zero-extended.
  - LW (010) returns the full word.
- Illegal funct3 (011, 110, 111; and 100/101 for stores) or misalignment (half with addr[0]=1; word with addr[1:0]!=0):
  - no RAM write;
  - resp_rdata=0;
  - misaligned=1 during RESP.
- Once accepted, a request completes even if req_valid drops during WAIT. Inputs are sampled only at accept.

## Timing
- Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, misaligned 0, stall 0 (combinational on req_valid), RAM cleared to 0.
- Latency: accept edge T, resp_valid high in cycle T+WAIT_CYCLES+1. Stall is high for WAIT_CYCLES+1 cycles per access.
- Back-to-back: a request present in the cycle after RESP is a new request. At most one access per WAIT_CYCLES+2 cycles.
- Reset mid-WAIT: access aborted, no RAM write, IDLE next cycle. Reset during RESP: resp_valid low next cycle.
- Store then load to the same word: the load observes the store, because the write commits before the load is accepted.
- Counter width 4 bits; no wrap (WAIT_CYCLES ≤ 15 is enforced by an elaboration check).

## Structure
- dmem_pkg: state enum (IDLE/WAIT/RESP); funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module load_store_align (combinational):
  - inputs: funct3, lane, wdata, old word, read word;
  - outputs: merged store word, byte enables, extended load data, illegal flag.
- Top block holds the FSM, counter, latches and RAM array.

## Test plan
- Reset, WAIT_CYCLES=2: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> stall high 3 cycles each, resp_rdata=0xDEADBEEF three cycles after accept.
- SB 0x013 data 0x80 over word 0x11223344, then LB 0x013 -> 0xFFFFFF80; LBU -> 0x00000080; LW -> 0x80223344.
- SH 0x022 data 0x1234 over word 0, then LH 0x022 -> 0x00001234; LHU 0x020 -> 0x00000000.
- LW 0x005 -> misaligned=1, resp_rdata=0. SH 0x001 -> misaligned=1, word unchanged.
- WAIT_CYCLES=0: accept then resp_valid next cycle, stall high exactly 1 cycle; back-to-back SW/LW same address returns the stored value.
- Reset asserted one cycle after a store accept (WAIT_CYCLES=4) -> no write, RAM word reads 0, FSM IDLE.
